rr_arbiter_8: RTL and testbench

Round-robin arbiter sharing one resource among 8 requesters. It registers a 3-bit grant index and drives it through a 3-to-8 one-hot decode to produce the per-requester grant lines. It sits between the requesting blocks and the shared datapath, and guarantees exactly zero or one grant active per cycle. A per-grant hold limit prevents one requester from starving the others.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_pick_8.sv | 35 +++
 rtl/rr_arbiter_8.sv | 101 ++++++++++
 tb/tb_rr_arbiter_8.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding
// and the index-to-one-hot grant decode.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = 8'h01 << idx;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority encoder: first set request scanning from ptr upward,
// wrapping past 7 back to 0.
module rr_pick_8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;
    logic [IDX_W-1:0] pos_s;

    // scan the eight positions starting at ptr; the first hit wins
    always_comb begin
        idx_s   = 3'd0;
        found_s = 1'b0;
        pos_s   = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            pos_s = ptr + 3'(i);
            if (!found_s && req[pos_s]) begin
                idx_s   = pos_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx = idx_s;
    assign any = found_s;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a per-grant hold limit and a
// mandatory idle cycle between consecutive grants.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e       state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic [N_REQ-1:0] others_s;
    logic             release_s;
    logic [N_REQ-1:0] grant_s;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // state, pointer, hold counter and grant index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 3'd0;
            idx_r   <= 3'd0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
        end
    end

    // next-state: pick from IDLE, release on drop or on limit with a competitor
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        others_s  = req & ~onehot8(idx_r);
        release_s = !req[idx_r] || ((cnt_r == CNT_LAST) && (others_s != 8'h00));
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = GRANT;
                    idx_s   = pick_idx_s;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_s = IDLE;
                    ptr_s   = idx_r + 3'd1;
                end else if (cnt_r != CNT_LAST) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // grant lines decode only from registered state, never from req
    always_comb begin
        grant_s = 8'h00;
        if (state_r == GRANT) begin
            grant_s = onehot8(idx_r);
        end else begin
            grant_s = 8'h00;
        end
    end

    assign grant       = grant_s;
    assign grant_idx   = idx_r;
    assign grant_valid = (state_r == GRANT);
    assign busy        = (state_r == GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized self-checking bench for rr_arbiter_8 against a cycle-level
// behavioural model of the round-robin rules (HOLD_MAX = 4).
module tb_rr_arbiter_8;
    import rr_arb_pkg::*;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: who owns the resource and for how many cycles so far
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic rn);
        int others;
        if (!rn) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && r[(m_ptr + k) % 8]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 1;
                end
            end
        end else begin
            others = int'(r) & ~(1 << m_owner);
            if (!r[m_owner] || (m_held >= HOLD && others != 0)) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_grant;
        exp_grant = m_busy ? 8'(1 << m_owner) : 8'h00;
        check("grant", grant, exp_grant);
        check("grant_idx", 8'(grant_idx), 8'(m_owner));
        check("grant_valid", 8'(grant_valid), 8'(m_busy));
        check("busy", 8'(busy), 8'(m_busy));
    endtask

    task automatic cyc(input logic [7:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        model_step(r, rn);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] rq;
        logic       rn;
        logic [2:0] iv;

        for (int i = 0; i < 8; i++) begin
            iv = 3'(i);
            check("onehot8", onehot8(iv), 8'(1 << i));
        end

        // reset held with every line requesting
        cyc(8'hFF, 1'b0);
        cyc(8'hFF, 1'b0);
        check("reset_grant", grant, 8'h00);
        check("reset_valid", 8'(grant_valid), 8'h00);
        cyc(8'hFF, 1'b1);
        check("first_grant", grant, 8'h01);

        // full rotation under constant contention
        for (int i = 0; i < 44; i++) cyc(8'hFF, 1'b1);

        // lone requester 4
        cyc(8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        cyc(8'h10, 1'b1);
        check("idx4", 8'(grant_idx), 8'h04);
        check("grant4", grant, 8'h10);
        for (int i = 0; i < 3; i++) cyc(8'h10, 1'b1);
        cyc(8'h00, 1'b1);
        check("drop4", grant, 8'h00);

        // 7 and 0 competing, 7 drops after two cycles
        for (int i = 0; i < 12; i++) cyc(8'h81, 1'b1);
        for (int i = 0; i < 12; i++) cyc((i % 3 == 2) ? 8'h01 : 8'h81, 1'b1);

        // single requester never released
        cyc(8'h00, 1'b1);
        for (int i = 0; i < 100; i++) cyc(8'h04, 1'b1);
        check("hold_no_comp", grant, 8'h04);

        // reset in the middle of a grant
        for (int i = 0; i < 3; i++) cyc(8'h08, 1'b1);
        cyc(8'h08, 1'b0);
        check("mid_reset", grant, 8'h00);
        cyc(8'h88, 1'b1);
        check("post_reset", grant, 8'h08);
        for (int i = 0; i < 10; i++) cyc(8'h88, 1'b1);

        // random traffic with persistent requests and occasional reset
        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7, 0) == 0) rq[b] = ~rq[b];
            end
            rn = ($urandom_range(299, 0) != 0);
            cyc(rq, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
